// File: rtl/param_fifo.sv
// Single-clock parameterised FIFO with registered occupancy flags,
// selectable standard or first-word-fall-through read, and overflow/underflow pulses.
module param_fifo #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned AF_LEVEL = DEPTH - 2,
    parameter int unsigned AE_LEVEL = 2,
    parameter int unsigned FWFT     = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         din,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_ptr_nxt;
    logic [CNT_W-1:0] count_nxt;
    logic [WIDTH-1:0] head_nxt;
    logic             wr_ok;
    logic             rd_ok;

    // Accept decisions, next occupancy and the word that will sit at the head after this edge.
    always_comb begin
        wr_ok      = wr_en && !full;
        rd_ok      = rd_en && !empty;
        rd_ptr_nxt = rd_ok ? rd_ptr + PTR_W'(1) : rd_ptr;
        count_nxt  = count;
        if (wr_ok && !rd_ok) begin
            count_nxt = count + CNT_W'(1);
        end else if (rd_ok && !wr_ok) begin
            count_nxt = count - CNT_W'(1);
        end
        // The head slot is being written this edge only when the FIFO drains to that same slot.
        head_nxt = (wr_ok && (wr_ptr == rd_ptr_nxt)) ? din : mem[rd_ptr_nxt];
    end

    // Storage is not cleared by reset; reset only blocks the write.
    always_ff @(posedge clk) begin
        if (!rst && wr_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers, occupancy, flags and read data; flags are derived from the next count so they never lag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
            dout         <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            rd_ptr       <= rd_ptr_nxt;
            count        <= count_nxt;
            full         <= (count_nxt == CNT_W'(DEPTH));
            empty        <= (count_nxt == '0);
            almost_full  <= (count_nxt >= CNT_W'(AF_LEVEL));
            almost_empty <= (count_nxt <= CNT_W'(AE_LEVEL));
            overflow     <= wr_en && full;
            underflow    <= rd_en && empty;
            if (FWFT != 0) begin
                dout <= head_nxt;
            end else if (rd_ok) begin
                dout <= mem[rd_ptr];
            end
        end
    end

endmodule

// File: tb/tb_param_fifo.sv
// Scoreboard bench for param_fifo: a standard-read and a FWFT instance share stimulus,
// a queue-based reference model pushes per-cycle expectations, a monitor pops and compares.
module tb_param_fifo;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned AF    = 14;
    localparam int unsigned AE    = 2;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic             clk;
    logic             rst;
    logic             wr_en;
    logic             rd_en;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;
    logic [WIDTH-1:0] dout_f;
    logic             full, empty, almost_full, almost_empty, overflow, underflow;
    logic             full_f, empty_f, almost_full_f, almost_empty_f, overflow_f, underflow_f;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_f;

    param_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(0)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en), .dout(dout),
        .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
        .count(count), .overflow(overflow), .underflow(underflow)
    );

    param_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1)) dut_f (
        .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en), .dout(dout_f),
        .full(full_f), .empty(empty_f), .almost_full(almost_full_f), .almost_empty(almost_empty_f),
        .count(count_f), .overflow(overflow_f), .underflow(underflow_f)
    );

    typedef struct {
        int cnt;
        bit full;
        bit empty;
        bit af;
        bit ae;
        bit ovf;
        bit udf;
        int dout;
        bit head_vld;
        int head;
    } exp_t;

    exp_t exp_q[$];
    int   model_q[$];
    int   model_dout;
    int   n_vec;
    int   n_fail;
    bit   done;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s t=%0t actual=0x%0h required=0x%0h", name, $time, act, req);
        end
    endtask

    // Drive one cycle of stimulus and push what both instances must show after the coming edge.
    task automatic cyc(input bit r, input bit w, input int d, input bit rd);
        exp_t e;
        bit   was_full, was_empty;
        rst   = r;
        wr_en = w;
        din   = WIDTH'(d);
        rd_en = rd;
        if (r) begin
            model_q.delete();
            model_dout = 0;
            e.ovf = 0;
            e.udf = 0;
        end else begin
            was_full  = (model_q.size() == DEPTH);
            was_empty = (model_q.size() == 0);
            if (rd && !was_empty) model_dout = model_q.pop_front();
            if (w && !was_full) model_q.push_back(d & 8'hFF);
            e.ovf = w && was_full;
            e.udf = rd && was_empty;
        end
        e.cnt      = model_q.size();
        e.full     = (e.cnt == DEPTH);
        e.empty    = (e.cnt == 0);
        e.af       = (e.cnt >= AF);
        e.ae       = (e.cnt <= AE);
        e.dout     = model_dout;
        e.head_vld = (e.cnt > 0);
        e.head     = e.head_vld ? model_q[0] : 0;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    // Monitor: one expectation per rising edge, sampled just after it.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("count",        int'(count),        e.cnt);
                check("full",         int'(full),         int'(e.full));
                check("empty",        int'(empty),        int'(e.empty));
                check("almost_full",  int'(almost_full),  int'(e.af));
                check("almost_empty", int'(almost_empty), int'(e.ae));
                check("overflow",     int'(overflow),     int'(e.ovf));
                check("underflow",    int'(underflow),    int'(e.udf));
                check("dout",         int'(dout),         e.dout);
                check("fwft_count",   int'(count_f),      e.cnt);
                check("fwft_empty",   int'(empty_f),      int'(e.empty));
                check("fwft_ovf",     int'(overflow_f),   int'(e.ovf));
                if (e.head_vld) check("fwft_dout", int'(dout_f), e.head);
            end
        end
    end

    initial begin
        int d;
        n_vec = 0;
        n_fail = 0;
        model_dout = 0;
        done = 0;

        cyc(1, 0, 0, 0);
        for (int i = 1; i <= 16; i++) cyc(0, 1, i, 0);
        cyc(0, 1, 8'hAA, 0);
        cyc(0, 0, 0, 0);
        for (int i = 0; i < 16; i++) cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 0);

        // Steady state at eight entries with concurrent traffic across pointer wrap.
        d = 8'h20;
        for (int i = 0; i < 8; i++) begin cyc(0, 1, d, 0); d++; end
        for (int i = 0; i < 40; i++) begin cyc(0, 1, d, 1); d++; end
        for (int i = 0; i < 8; i++) cyc(0, 0, 0, 1);

        cyc(0, 1, 8'h5A, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 0);

        for (int i = 0; i < 10; i++) cyc(0, 1, 8'h40 + i, 0);
        cyc(1, 1, 8'hEE, 1);
        cyc(0, 0, 0, 0);

        for (int i = 0; i < 16; i++) cyc(0, 1, 8'h80 + i, 0);
        cyc(0, 1, 8'hBB, 1);
        cyc(0, 0, 0, 0);
        for (int i = 0; i < 15; i++) cyc(0, 0, 0, 1);
        cyc(0, 1, 8'hCC, 1);
        cyc(0, 0, 0, 0);

        for (int i = 0; i < 2000; i++) begin
            cyc(($urandom_range(0, 199) == 0), 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
        end
        cyc(0, 0, 0, 0);

        repeat (3) @(posedge clk);
        #2;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
